// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams an instruction image into the
// instruction memory write port and holds the core until the image is verified.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          WR_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic [15:0] mem_data_in,
    output logic        mem_wr,
    input  logic        mem_wr_success,
    input  logic        mem_err,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam int TW = $clog2(WR_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(WR_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   words_q, words_d;
    logic [7:0]    chk_q, chk_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [15:0]   n_w;
    logic [17:0]   end_addr;
    logic [15:0]   words_inc;

    // Word count as it stands once the low length byte is taken.
    assign n_w       = {count_q[15:8], s_data};
    assign end_addr  = {2'b00, BASE_ADDR} + {1'b0, n_w, 1'b0};
    assign words_inc = words_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            words_q <= '0;
            chk_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            words_q <= words_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        words_d = words_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    words_d = '0;
                    chk_d   = '0;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (s_valid) begin
                    count_d = {s_data, 8'h00};
                    chk_d   = chk_q ^ s_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (s_valid) begin
                    count_d = n_w;
                    chk_d   = chk_q ^ s_data;
                    if (end_addr > 18'h10000) state_d = ERROR;
                    else if (n_w == 16'd0)    state_d = CHK;
                    else                      state_d = DAT_HI;
                end
            end
            DAT_HI: begin
                if (s_valid) begin
                    hi_d    = s_data;
                    chk_d   = chk_q ^ s_data;
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (s_valid) begin
                    chk_d   = chk_q ^ s_data;
                    addr_d  = BASE_ADDR + {words_q[14:0], 1'b0};
                    data_d  = {hi_q, s_data};
                    tmo_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // An error response takes priority over a simultaneous success.
                if (mem_err) begin
                    state_d = ERROR;
                end else if (mem_wr_success) begin
                    words_d = words_inc;
                    state_d = (words_inc == count_q) ? CHK : DAT_HI;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHK: begin
                if (s_valid) state_d = (s_data == chk_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready      = 1'b0;
        mem_enable   = 1'b0;
        core_hold    = 1'b1;
        load_done    = 1'b0;
        load_err     = 1'b0;
        mem_addr     = addr_q;
        mem_data_in  = data_q;
        words_loaded = words_q;
        unique case (state_q)
            LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK: s_ready = 1'b1;
            WRITE: mem_enable = 1'b1;
            DONE: begin
                load_done = 1'b1;
                core_hold = 1'b0;
            end
            ERROR: load_err = 1'b1;
            default: ;
        endcase
        mem_wr = mem_enable;
    end

endmodule
